// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default parameters and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 4;
    localparam int WR_COUNT_W     = 16;

    // Ceiling log2 that never returns less than 1, so a derived vector width
    // is always legal even for degenerate parameter values.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals seen by the write arbiter.
// master: the arbiter; slave: the requesters plus FIFO that surround it.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = fifo_arb_pkg::DEF_NUM_REQ,
    parameter int DATA_WIDTH = fifo_arb_pkg::DEF_DATA_WIDTH
);
    localparam int OW = fifo_arb_pkg::clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [OW-1:0]                 owner;
    logic [fifo_arb_pkg::WR_COUNT_W-1:0] wr_count;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_data, owner, wr_count
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_data, owner, wr_count
    );

endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational circular first-set search: scans req starting at start_i and
// wrapping, reporting the first requester found.
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IW     = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      start_i,
    output logic               found_o,
    output logic [IW-1:0]      sel_o
);

    // Walk the requesters in priority order; the first hit wins.
    always_comb begin
        int          k;
        logic [IW-1:0] idx;
        found_o = 1'b0;
        sel_o   = '0;
        k       = 0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k   = (int'(start_i) + i) % NUM_REQ;
            idx = IW'(k);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and full-flag back-pressure.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant; pick next requester circularly from owner+1
//   GRANT | gnt[owner] held; each accepted word counts toward the burst
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fifo_wr_arbiter_if.master bus
);

    localparam int OW = clog2_min1(NUM_REQ);
    localparam int BW = clog2_min1(BURST_MAX + 1);

    localparam logic [OW-1:0] OWNER_LAST = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_MAX - 1);

    arb_state_t                state_q, state_d;
    logic [OW-1:0]             owner_q, owner_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [WR_COUNT_W-1:0]     wr_count_q, wr_count_d;

    logic [OW-1:0]             pick_start;
    logic                      pick_found;
    logic [OW-1:0]             pick_sel;
    logic                      accept;
    logic [DATA_WIDTH-1:0]     words [NUM_REQ];

    // Priority begins just past the last grantee, wrapping at NUM_REQ-1.
    always_comb begin
        pick_start = (owner_q == OWNER_LAST) ? '0 : owner_q + 1'b1;
    end

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (bus.req),
        .start_i (pick_start),
        .found_o (pick_found),
        .sel_o   (pick_sel)
    );

    // Split the flat requester data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state logic: grant selection, accept qualification and release.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        beat_d     = beat_q;
        wr_count_d = wr_count_q;
        accept     = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    owner_d = pick_sel;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_sel;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                // Reset suppresses the in-flight word so nothing lands in the FIFO.
                accept = bus.req[owner_q] & ~bus.fifo_full & ~reset_i;
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (accept) begin
                    beat_d     = beat_q + 1'b1;
                    wr_count_d = wr_count_q + 1'b1;
                    // Burst limit only releases on an actual accept, so a full
                    // FIFO defers the release rather than shortening the burst.
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_LAST;
            gnt_q      <= '0;
            beat_q     <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            beat_q     <= beat_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.owner      = owner_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_data  = words[owner_q];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester instance for the arbitration
// scenarios and a 2-requester, long-burst instance for the write-counter wrap.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
    fifo_wr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus2 ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_MAX  (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    fifo_wr_arbiter #(
        .NUM_REQ    (2),
        .DATA_WIDTH (8),
        .BURST_MAX  (256)
    ) dut2 (
        .clk_i   (clk),
        .reset_i (reset2),
        .bus     (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sizes [3];
        int n;
        int m;

        sizes = '{4, 4, 2};

        reset          = 1'b1;
        reset2         = 1'b1;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.fifo_full  = 1'b0;
        bus2.req       = '0;
        bus2.req_data  = '0;
        bus2.fifo_full = 1'b0;

        // Reset values
        repeat (2) tick();
        chk("rst_gnt",      32'(bus.gnt),        32'h0);
        chk("rst_owner",    32'(bus.owner),      32'h3);
        chk("rst_wr_count", 32'(bus.wr_count),   32'h0);
        chk("rst_wr_en",    32'(bus.fifo_wr_en), 32'h0);

        // Single word from requester 0
        reset                 = 1'b0;
        bus.req               = 4'b0001;
        bus.req_data[7:0]     = 8'hA5;
        tick();
        chk("single_gnt",   32'(bus.gnt),   32'h1);
        chk("single_owner", 32'(bus.owner), 32'h0);
        #1;
        chk("single_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        chk("single_data",  32'(bus.fifo_data),  32'hA5);
        tick();
        chk("single_count", 32'(bus.wr_count), 32'h1);
        chk("single_hold",  32'(bus.gnt),      32'h1);
        bus.req = 4'b0000;
        #1;
        chk("single_drop_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        tick();
        chk("single_release", 32'(bus.gnt), 32'h0);

        // All four requesting: four full bursts in round-robin order
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt",   32'(bus.gnt),   32'(1 << i));
            chk("rr_owner", 32'(bus.owner), 32'(i));
            for (int b = 0; b < 4; b++) begin
                chk("rr_wr_en", 32'(bus.fifo_wr_en), 32'h1);
                chk("rr_data",  32'(bus.fifo_data),  32'(8'h11 * (i + 1)));
                tick();
            end
            chk("rr_gap", 32'(bus.gnt), 32'h0);
        end
        chk("rr_count", 32'(bus.wr_count), 32'd16);
        bus.req = 4'b0000;

        // Lone requester 2 with 10 words: bursts of 4, 4, 2
        bus.req            = 4'b0100;
        n                  = 0;
        bus.req_data[23:16] = 8'h30;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("solo_gnt", 32'(bus.gnt), 32'h4);
            for (int b = 0; b < sizes[s]; b++) begin
                #1;
                chk("solo_wr_en", 32'(bus.fifo_wr_en), 32'h1);
                chk("solo_data",  32'(bus.fifo_data),  32'(8'h30 + n));
                tick();
                n++;
                bus.req_data[23:16] = 8'(8'h30 + n);
                if (n == 10) bus.req = 4'b0000;
            end
            if (sizes[s] == 4) begin
                chk("solo_gap", 32'(bus.gnt), 32'h0);
            end else begin
                #1;
                chk("solo_tail_gnt",   32'(bus.gnt),        32'h4);
                chk("solo_tail_wr_en", 32'(bus.fifo_wr_en), 32'h0);
                tick();
                chk("solo_tail_release", 32'(bus.gnt), 32'h0);
            end
        end
        chk("solo_count", 32'(bus.wr_count), 32'd26);

        // Full stall on the last beat of a burst from requester 1
        bus.req            = 4'b0010;
        m                  = 0;
        bus.req_data[15:8] = 8'h50;
        tick();
        chk("full_gnt",   32'(bus.gnt),   32'h2);
        chk("full_owner", 32'(bus.owner), 32'h1);
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("full_pre_wr_en", 32'(bus.fifo_wr_en), 32'h1);
            chk("full_pre_data",  32'(bus.fifo_data),  32'(8'h50 + m));
            tick();
            m++;
            bus.req_data[15:8] = 8'(8'h50 + m);
        end
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("full_stall_wr_en", 32'(bus.fifo_wr_en), 32'h0);
            chk("full_stall_gnt",   32'(bus.gnt),        32'h2);
            tick();
        end
        chk("full_stall_count", 32'(bus.wr_count), 32'd29);
        bus.fifo_full = 1'b0;
        #1;
        chk("full_last_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        chk("full_last_data",  32'(bus.fifo_data),  32'h53);
        tick();
        chk("full_release", 32'(bus.gnt),      32'h0);
        chk("full_count",   32'(bus.wr_count), 32'd30);
        bus.req = 4'b0000;

        // Dropped request releases even while the FIFO is full
        bus.req = 4'b0001;
        tick();
        chk("drop_gnt", 32'(bus.gnt), 32'h1);
        bus.fifo_full = 1'b1;
        bus.req       = 4'b0000;
        #1;
        chk("drop_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        tick();
        chk("drop_release", 32'(bus.gnt),      32'h0);
        chk("drop_count",   32'(bus.wr_count), 32'd30);
        bus.fifo_full = 1'b0;

        // Reset on the second beat of a burst from requester 1
        bus.req            = 4'b0010;
        bus.req_data[15:8] = 8'h66;
        tick();
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h2);
        #1;
        chk("mid_rst_first_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        tick();
        chk("mid_rst_first_count", 32'(bus.wr_count), 32'd31);
        bus.req_data[15:8] = 8'h67;
        reset              = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        tick();
        chk("mid_rst_gnt_after",   32'(bus.gnt),      32'h0);
        chk("mid_rst_owner_after", 32'(bus.owner),    32'h3);
        chk("mid_rst_count_after", 32'(bus.wr_count), 32'h0);
        reset   = 1'b0;
        bus.req = 4'b0000;

        // wr_count wrap: requester 0 alone, bursts of 256 with one gap cycle.
        // After t edges: writes = (t/257)*256 + max(0, t%257 - 1).
        reset2              = 1'b0;
        bus2.req            = 2'b01;
        bus2.req_data[7:0]  = 8'hC3;
        repeat (65791) tick();
        chk("wrap_ffff", 32'(bus2.wr_count), 32'hFFFF);
        repeat (3) tick();
        chk("wrap_0001",   32'(bus2.wr_count), 32'h0001);
        chk("wrap_gnt",    32'(bus2.gnt),      32'h1);
        bus2.req = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO, drives its write enable and write data, and honours its `full` flag. Bursts are bounded, so no requester can hold the port indefinitely. Grants are registered; write enable is qualified combinationally with `full` so no word is ever pushed into a full FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `BURST_MAX`, 4: maximum accepted words per grant, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: per-requester request; level, held while the requester has data.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt` out NUM_REQ: one-hot registered grant; all-zero when idle.
- `fifo_full` in 1: FIFO full flag.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_data` out DATA_WIDTH: FIFO write data, equal to the granted requester's word.
- `owner` out $clog2(NUM_REQ): index of the current or last grantee.
- `wr_count` out 16: total accepted words, wraps modulo 2^16.

## Operation
- FSM states: IDLE and GRANT.
- IDLE:
  - If any `req` is high, select the first set bit searching circularly from `owner+1`.
  - Load `owner` and `gnt`, clear `beat_cnt`, go to GRANT.
  - If no `req` is high, stay in IDLE with `gnt`=0.
- GRANT, accept condition: `req[owner] & ~fifo_full`.
  - `fifo_wr_en` = accept; `fifo_data` = `req_data[owner]`.
- GRANT, on each accept: `beat_cnt`++ and `wr_count`++.
- GRANT, release when either condition holds, then go to IDLE with `gnt`=0 next cycle:
  - `req[owner]` is low; or
  - an accept occurs with `beat_cnt == BURST_MAX-1`.
- Full stall: while `fifo_full` is high, hold the grant. `beat_cnt` does not advance, and stall cycles do not count toward the burst.
- Release on burst limit with `req[owner]` still high:
  - The next IDLE cycle rotates priority past the owner.
  - The owner is regranted only if no other requester is asking.
- Requester rule: a requester changes `req_data` only on a cycle after its word was accepted (`gnt[i] & req[i] & ~fifo_full` at the edge).
- Widths:
  - `beat_cnt` is $clog2(BURST_MAX+1) bits.
  - `wr_count` wraps FFFF→0000 with no flag.

## Timing
- Reset values:
  - state=IDLE, `gnt`=0, `owner`=NUM_REQ-1 (so requester 0 has first priority), `beat_cnt`=0, `wr_count`=0.
  - `fifo_wr_en`=0, `fifo_data`=`req_data[owner]` (don't-care).
- `fifo_wr_en` is additionally forced 0 on every cycle where `reset` is high.
- Latency:
  - `req` sampled high in IDLE at edge k → `gnt` high after edge k → first word written at edge k+1.
  - Back-to-back bursts have one idle (gap) cycle between them.
- Reset mid-burst: the in-flight word is not written. After the edge, state matches the reset values above.
- Requester drops `req` while granted: no write that cycle; release at that edge.
- `fifo_full` and release on the same cycle: a low `req` still releases; a burst release requires an accept, so a full FIFO defers it.
- Maximum throughput: BURST_MAX words per BURST_MAX+1 cycles.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - function `clog2_min1`;
  - default parameter constants.
- Sub-module `fifo_rr_picker`: combinational; inputs `req` and `start` index; outputs `found` and the selected index.
- Top level holds the FSM, counters and the data mux.

## Test plan
- Reset, then `req`=0001 → `gnt`=0001 one cycle later; one word 0xA5 written on the next edge; `wr_count`=1.
- `req`=1111 held for 4 full bursts, BURST_MAX=4 → owners in order 0,1,2,3; each writes 4 words; gap of 1 cycle between bursts; `wr_count`=16.
- Only `req[2]` held with 10 words, BURST_MAX=4 → bursts of 4,4,2 all to owner 2; `gnt` deasserts for 1 cycle between bursts.
- `fifo_full` high for 5 cycles mid-burst → `fifo_wr_en`=0 and `gnt` held throughout; the burst still completes all 4 words after `full` falls.
- Reset asserted during the second beat of a burst → no write on that edge; `gnt`=0, `owner`=3, `wr_count`=0 afterwards.
- `wr_count` preloaded by running 65535 writes, then 2 more → wraps to 0001.
